// File: rtl/cla_mp_add_seq.sv
//==============================================================================
// Module      : cla_mp_add_seq (with helper cla_32bits)
// Description : Multi-precision adder sequencer. It adds two WORDS*WIDTH-bit
//               operands one 32-bit word per cycle through a shared CLA.
//               Optional macro CLA_SEQ_SUB_EN adds the in_sub port (A-B mode).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module cla_32bits (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        ci,
    output logic [31:0] s,
    output logic        co
);

    logic [31:0] w_g;
    logic [31:0] w_p;
    logic [32:0] w_c;
    logic [7:0]  w_gg;
    logic [7:0]  w_pg;

    assign w_g    = a & b;
    assign w_p    = a ^ b;
    assign w_c[0] = ci;

    // Each 4-bit group resolves its internal carries and exports group G/P.
    // The carry into the next group is then formed from G/P in one step.
    genvar j;
    generate
        for (j = 0; j < 8; j++) begin : g_grp
            localparam int B = 4 * j;

            assign w_c[B+1] = w_g[B]
                            | (w_p[B] & w_c[B]);
            assign w_c[B+2] = w_g[B+1]
                            | (w_p[B+1] & w_g[B])
                            | (w_p[B+1] & w_p[B] & w_c[B]);
            assign w_c[B+3] = w_g[B+2]
                            | (w_p[B+2] & w_g[B+1])
                            | (w_p[B+2] & w_p[B+1] & w_g[B])
                            | (w_p[B+2] & w_p[B+1] & w_p[B] & w_c[B]);

            assign w_gg[j]  = w_g[B+3]
                            | (w_p[B+3] & w_g[B+2])
                            | (w_p[B+3] & w_p[B+2] & w_g[B+1])
                            | (w_p[B+3] & w_p[B+2] & w_p[B+1] & w_g[B]);
            assign w_pg[j]  = &w_p[B+3:B];

            assign w_c[B+4] = w_gg[j] | (w_pg[j] & w_c[B]);
        end
    endgenerate

    assign s  = w_p ^ w_c[31:0];
    assign co = w_c[32];

endmodule

module cla_mp_add_seq #(
    parameter int WIDTH = 32,
    parameter int WORDS = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WORDS*WIDTH-1:0] in_a,
    input  logic [WORDS*WIDTH-1:0] in_b,
    input  logic                   in_ci,
`ifdef CLA_SEQ_SUB_EN
    input  logic                   in_sub,
`endif
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WORDS*WIDTH-1:0] out_sum,
    output logic                   out_co,
    output logic                   busy
);

    localparam int TOTAL = WORDS * WIDTH;
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    generate
        if (WIDTH != 32) begin : g_width_err
            $error("cla_mp_add_seq: WIDTH must be 32");
        end
        if ((WORDS < 1) || (WORDS > 64)) begin : g_words_err
            $error("cla_mp_add_seq: WORDS must be in 1..64");
        end
    endgenerate

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] idx_q,   idx_d;
    logic             carry_q, carry_d;
    logic [TOTAL-1:0] a_q,     a_d;
    logic [TOTAL-1:0] b_q,     b_d;
    logic [TOTAL-1:0] sum_q,   sum_d;
    logic             co_q,    co_d;
    logic             valid_q, valid_d;
`ifdef CLA_SEQ_SUB_EN
    logic             sub_q,   sub_d;
`endif

    logic [WIDTH-1:0] w_word_a;
    logic [WIDTH-1:0] w_word_b;
    logic [WIDTH-1:0] w_word_b_eff;
    logic             w_init_carry;
    logic [WIDTH-1:0] w_cla_s;
    logic             w_cla_co;
    logic             w_accept;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (in_valid)         state_d = ST_RUN;
            ST_RUN:  if (idx_q == LAST_IDX) state_d = ST_DONE;
            ST_DONE: if (out_ready)        state_d = ST_IDLE;
            default:                       state_d = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        in_ready = (state_q == ST_IDLE);
        busy     = (state_q != ST_IDLE);
    end

    assign w_accept = in_valid && (state_q == ST_IDLE);

    // Select the current word of each latched operand.
    always_comb begin
        w_word_a = '0;
        w_word_b = '0;
        for (int w = 0; w < WORDS; w++) begin
            if (idx_q == IDX_W'(w)) begin
                w_word_a = a_q[w*WIDTH +: WIDTH];
                w_word_b = b_q[w*WIDTH +: WIDTH];
            end
        end
    end

`ifdef CLA_SEQ_SUB_EN
    // Subtraction is A + ~B + 1; the +1 enters as the initial carry.
    assign w_word_b_eff = sub_q ? ~w_word_b : w_word_b;
    assign w_init_carry = in_sub ? 1'b1 : in_ci;
`else
    assign w_word_b_eff = w_word_b;
    assign w_init_carry = in_ci;
`endif

    cla_32bits u_cla (
        .a  (w_word_a),
        .b  (w_word_b_eff),
        .ci (carry_q),
        .s  (w_cla_s),
        .co (w_cla_co)
    );

    // ---------------- datapath next-state ----------------
    always_comb begin
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        co_d    = co_q;
        valid_d = valid_q;
`ifdef CLA_SEQ_SUB_EN
        sub_d   = sub_q;
`endif

        if (w_accept) begin
            a_d     = in_a;
            b_d     = in_b;
            carry_d = w_init_carry;
            idx_d   = '0;
            sum_d   = '0;
            co_d    = 1'b0;
`ifdef CLA_SEQ_SUB_EN
            sub_d   = in_sub;
`endif
        end

        if (state_q == ST_RUN) begin
            for (int w = 0; w < WORDS; w++) begin
                if (idx_q == IDX_W'(w)) begin
                    sum_d[w*WIDTH +: WIDTH] = w_cla_s;
                end
            end
            carry_d = w_cla_co;
            if (idx_q == LAST_IDX) begin
                co_d    = w_cla_co;
                valid_d = 1'b1;
            end else begin
                idx_d   = idx_q + 1'b1;
            end
        end

        if ((state_q == ST_DONE) && out_ready) begin
            valid_d = 1'b0;
        end
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            co_q    <= 1'b0;
            valid_q <= 1'b0;
`ifdef CLA_SEQ_SUB_EN
            sub_q   <= 1'b0;
`endif
        end else begin
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            co_q    <= co_d;
            valid_q <= valid_d;
`ifdef CLA_SEQ_SUB_EN
            sub_q   <= sub_d;
`endif
        end
    end

    assign out_valid = valid_q;
    assign out_sum   = sum_q;
    assign out_co    = co_q;

endmodule

`default_nettype wire
